// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet port receive path.
// Holds the FSM state enum, the buffer entry layout and a saturating counter helper.
package eth_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrop
    } rx_state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Two drops can land in one cycle (old packet abandoned plus new 1-word packet rejected).
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/eth_pkt_buf.sv
// Packet buffer with speculative write pointer, commit pointer and read pointer.
// Only entries between read and commit pointers are visible to the consumer.
module eth_pkt_buf
    import eth_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   wr_en,
    input  entry_t wr_entry,
    input  logic   rollback,
    input  logic   commit,
    input  logic   rd_en,
    output entry_t rd_entry,
    output logic   rd_valid,
    output logic   full_wr,
    output logic   full_cmt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q, cmt_ptr_q, rd_ptr_q;
    logic [AW:0] base_ptr;
    entry_t      mem [DEPTH];

    function automatic logic is_full(input logic [AW:0] wp, input logic [AW:0] rp);
        return (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    endfunction

    // A rollback in the same cycle as a write restarts the packet at the commit point.
    assign base_ptr = rollback ? cmt_ptr_q : wr_ptr_q;

    assign full_wr  = is_full(wr_ptr_q, rd_ptr_q);
    assign full_cmt = is_full(cmt_ptr_q, rd_ptr_q);
    assign rd_valid = (rd_ptr_q != cmt_ptr_q);
    assign rd_entry = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= base_ptr + PTR_ONE;
            end else if (rollback) begin
                wr_ptr_q <= cmt_ptr_q;
            end
            if (commit) begin
                cmt_ptr_q <= base_ptr + PTR_ONE;
            end
            if (rd_en && rd_valid) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[base_ptr[AW-1:0]] <= wr_entry;
        end
    end

endmodule

// File: rtl/eth_port_rx.sv
// Receive side of a switch port: frames words into packets, drops oversize, aborted
// or non-fitting packets, and exposes committed words through a first-word fall-through buffer.
module eth_port_rx
    import eth_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int MAX_WORDS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rxData,
    input  logic              rxSop,
    input  logic              rxEop,
    input  logic              rdEn,
    output logic [DATA_W-1:0] rdData,
    output logic              rdSop,
    output logic              rdEop,
    output logic              rdValid,
    output logic [CNT_W-1:0]  pktCount,
    output logic [CNT_W-1:0]  dropCount
);

    localparam int WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [WCNT_W-1:0] MAX_CNT  = WCNT_W'(MAX_WORDS);
    localparam logic [WCNT_W-1:0] CNT_ONE  = WCNT_W'(1);

    rx_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q, drop_cnt_q;

    logic       wr_en, rollback, commit, pkt_inc, start_pkt, restart, full_sel;
    logic [1:0] drop_inc;
    logic       full_wr, full_cmt, buf_valid;
    entry_t     wr_entry, rd_entry;

    assign wr_entry = '{sop: rxSop, eop: rxEop, data: rxData};

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        wr_en     = 1'b0;
        rollback  = 1'b0;
        commit    = 1'b0;
        pkt_inc   = 1'b0;
        drop_inc  = 2'd0;
        start_pkt = 1'b0;
        restart   = 1'b0;
        full_sel  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rxSop) begin
                    start_pkt = 1'b1;
                end else if (rxEop) begin
                    drop_inc = 2'd1;
                end
            end
            StRecv: begin
                if (rxSop) begin
                    restart   = 1'b1;
                    rollback  = 1'b1;
                    drop_inc  = 2'd1;
                    start_pkt = 1'b1;
                end else if (wcnt_q == MAX_CNT || full_wr) begin
                    rollback = 1'b1;
                    if (rxEop) begin
                        drop_inc = 2'd1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StDrop;
                    end
                end else begin
                    wr_en  = 1'b1;
                    wcnt_d = wcnt_q + CNT_ONE;
                    if (rxEop) begin
                        commit  = 1'b1;
                        pkt_inc = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDrop: begin
                if (rxSop) begin
                    drop_inc  = 2'd1;
                    start_pkt = 1'b1;
                end else if (rxEop) begin
                    drop_inc = 2'd1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // New packet head: fullness is judged at the commit point when restarting.
        if (start_pkt) begin
            full_sel = restart ? full_cmt : full_wr;
            if (rxEop) begin
                state_d = StIdle;
                if (full_sel) begin
                    drop_inc = drop_inc + 2'd1;
                end else begin
                    wr_en   = 1'b1;
                    commit  = 1'b1;
                    pkt_inc = 1'b1;
                end
            end else if (full_sel) begin
                state_d = StDrop;
            end else begin
                wr_en   = 1'b1;
                wcnt_d  = CNT_ONE;
                state_d = StRecv;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wcnt_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            pkt_cnt_q  <= sat_add(pkt_cnt_q, {1'b0, pkt_inc});
            drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
        end
    end

    eth_pkt_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .rollback (rollback),
        .commit   (commit),
        .rd_en    (rdEn),
        .rd_entry (rd_entry),
        .rd_valid (buf_valid),
        .full_wr  (full_wr),
        .full_cmt (full_cmt)
    );

    assign rdValid   = buf_valid;
    assign rdData    = rd_entry.data;
    assign rdSop     = buf_valid & rd_entry.sop;
    assign rdEop     = buf_valid & rd_entry.eop;
    assign pktCount  = pkt_cnt_q;
    assign dropCount = drop_cnt_q;

endmodule

// File: tb/tb_eth_port_rx.sv
// Bench for eth_port_rx: directed packet scenarios plus random packet mixes checked
// against a packet-level model (commit iff legal length and it fits in free space).
module tb_eth_port_rx;
    import eth_pkg::*;

    localparam int DEPTH = 64;
    localparam int MAXW  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] rxData = '0;
    logic              rxSop = 1'b0;
    logic              rxEop = 1'b0;
    logic              rdEn = 1'b0;
    logic [DATA_W-1:0] rdData;
    logic              rdSop, rdEop, rdValid;
    logic [CNT_W-1:0]  pktCount, dropCount;

    int errors = 0;
    int checks = 0;
    int exp_pkt = 0;
    int exp_drop = 0;
    logic [33:0] mq[$];

    eth_port_rx #(
        .DEPTH     (DEPTH),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxData    (rxData),
        .rxSop     (rxSop),
        .rxEop     (rxEop),
        .rdEn      (rdEn),
        .rdData    (rdData),
        .rdSop     (rdSop),
        .rdEop     (rdEop),
        .rdValid   (rdValid),
        .pktCount  (pktCount),
        .dropCount (dropCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic e, input logic [31:0] d);
        rxSop  = s;
        rxEop  = e;
        rxData = d;
        tick();
        rxSop  = 1'b0;
        rxEop  = 1'b0;
        rxData = $urandom;
    endtask

    // Whole-packet model: with no reads in flight, a complete packet commits iff its
    // length is legal and it fits; an aborted packet is always a single drop.
    task automatic send_pkt(input int len, input bit abort);
        logic [33:0] w[$];
        logic [31:0] d;
        logic        s, e;
        for (int i = 0; i < len; i++) begin
            d = $urandom;
            s = (i == 0);
            e = !abort && (i == len - 1);
            w.push_back({s, e, d});
            drive(s, e, d);
        end
        if (abort) begin
            exp_drop++;
        end else if (len <= MAXW && mq.size() + len <= DEPTH) begin
            foreach (w[i]) mq.push_back(w[i]);
            exp_pkt++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " pktCount"}, pktCount, exp_pkt);
        chk({tag, " dropCount"}, dropCount, exp_drop);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        rdEn = 1'b1;
        while (mq.size() > 0 && guard < 4 * DEPTH) begin
            guard++;
            if (rdValid !== 1'b1) begin
                chk({tag, " rdValid"}, rdValid, 1);
                break;
            end
            chk({tag, " word"}, {rdSop, rdEop, rdData}, mq.pop_front());
            tick();
        end
        rdEn = 1'b0;
        chk({tag, " empty"}, rdValid, 0);
        mq.delete();
    endtask

    initial begin
        int n, r;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rdValid", rdValid, 0);
        reset = 1'b0;
        tick();
        chk("reset rdSop", rdSop, 0);
        chk("reset rdEop", rdEop, 0);
        chk_counts("reset");

        // Pop request on an empty buffer must be ignored
        rdEn = 1'b1;
        repeat (2) tick();
        rdEn = 1'b0;
        chk("empty pop rdValid", rdValid, 0);

        // Three-word packet, uncommitted words stay hidden
        drive(1'b1, 1'b0, 32'h0000ABCD);
        drive(1'b0, 1'b0, 32'h76543210);
        chk("partial hidden", rdValid, 0);
        drive(1'b0, 1'b1, 32'h99999999);
        chk("commit visible", rdValid, 1);
        mq.push_back({2'b10, 32'h0000ABCD});
        mq.push_back({2'b00, 32'h76543210});
        mq.push_back({2'b01, 32'h99999999});
        exp_pkt++;
        chk_counts("pkt3");
        drain("pkt3");

        // Single-word packet
        drive(1'b1, 1'b1, 32'h1);
        chk("one-word rdValid", rdValid, 1);
        chk("one-word flags", {rdSop, rdEop}, 2'b11);
        mq.push_back({2'b11, 32'h1});
        exp_pkt++;
        drain("one-word");
        chk_counts("one-word");

        // Oversize packet then a normal one
        send_pkt(MAXW + 1, 1'b0);
        chk("oversize hidden", rdValid, 0);
        chk_counts("oversize");
        send_pkt(2, 1'b0);
        drain("after oversize");
        chk_counts("after oversize");

        // Aborted packet restarted by a new sop
        drive(1'b1, 1'b0, 32'h11);
        drive(1'b1, 1'b0, 32'h22);
        drive(1'b0, 1'b1, 32'h33);
        mq.push_back({2'b10, 32'h22});
        mq.push_back({2'b01, 32'h33});
        exp_pkt++;
        exp_drop++;
        chk_counts("abort");
        drain("abort");

        // Orphan eop outside a packet
        drive(1'b0, 1'b1, 32'hDEAD);
        exp_drop++;
        chk_counts("orphan eop");

        // Fill the buffer: two fit, third is dropped; drain wraps the pointers
        for (int i = 0; i < 3; i++) send_pkt(MAXW, 1'b0);
        chk_counts("fill");
        chk("fill depth", mq.size(), DEPTH);
        drain("fill");
        send_pkt(5, 1'b0);
        drain("post wrap");
        chk_counts("post wrap");

        // Random packet mixes
        for (int round = 0; round < 20; round++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    drive(1'b0, 1'b1, $urandom);
                    exp_drop++;
                end else if (r == 1) begin
                    send_pkt($urandom_range(1, 5), 1'b1);
                    send_pkt($urandom_range(1, MAXW), 1'b0);
                end else begin
                    send_pkt($urandom_range(1, MAXW + 3), 1'b0);
                end
                repeat ($urandom_range(0, 2)) tick();
            end
            chk_counts("random");
            drain("random");
        end

        // Reset in the middle of a packet with committed data present
        drive(1'b1, 1'b1, 32'h5);
        drive(1'b1, 1'b0, 32'hA);
        drive(1'b0, 1'b0, 32'hB);
        reset = 1'b1;
        #1;
        chk("async rdValid", rdValid, 0);
        chk("async rdSop", rdSop, 0);
        chk("async rdEop", rdEop, 0);
        mq.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        chk_counts("async reset");
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'hC1);
        drive(1'b0, 1'b0, 32'hC2);
        drive(1'b0, 1'b1, 32'hC3);
        mq.push_back({2'b10, 32'hC1});
        mq.push_back({2'b00, 32'hC2});
        mq.push_back({2'b01, 32'hC3});
        exp_pkt++;
        chk_counts("after reset");
        drain("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
